// File: rtl/hdmi_island_pkg.sv
// Shared constants and state definitions for the HDMI data-island scheduler.
//   PREAMBLE_LEN / GUARD_LEN / PACKET_LEN : fixed island framing lengths in pixel clocks
//   island_state_e / ST_*                  : FSM state encoding (ST_* are the legacy-style constants)
//   slot_budget()                          : packet slots that fit in one horizontal blanking
package hdmi_island_pkg;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;

    typedef enum logic [2:0] {
        ISL_IDLE        = 3'd0,
        ISL_DELAY       = 3'd1,
        ISL_PREAMBLE    = 3'd2,
        ISL_LEAD_GUARD  = 3'd3,
        ISL_PACKET      = 3'd4,
        ISL_TRAIL_GUARD = 3'd5
    } island_state_e;

    localparam logic [2:0] ST_IDLE        = ISL_IDLE;
    localparam logic [2:0] ST_DELAY       = ISL_DELAY;
    localparam logic [2:0] ST_PREAMBLE    = ISL_PREAMBLE;
    localparam logic [2:0] ST_LEAD_GUARD  = ISL_LEAD_GUARD;
    localparam logic [2:0] ST_PACKET      = ISL_PACKET;
    localparam logic [2:0] ST_TRAIL_GUARD = ISL_TRAIL_GUARD;

    // Whole packets that fit between the start delay and the video reserve,
    // capped by the per-island HDMI limit. Never negative.
    function automatic int slot_budget(input int h_blank, input int start_delay,
                                       input int video_reserve, input int max_packets);
        int avail;
        avail = (h_blank - start_delay - PREAMBLE_LEN - 2 * GUARD_LEN - video_reserve) / PACKET_LEN;
        if (avail < 0) avail = 0;
        return (avail < max_packets) ? avail : max_packets;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the island packet slots.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   req_i          : level requests, one per source
//   advance_i      : the current winner is taken; move the pointer past it
//   grant_o        : one-hot winner (combinational), zero when no request
//   grant_idx_o    : index of the winner
// The search starts at the pointer; after an accepted grant the pointer
// becomes winner+1 (mod NUM_REQ), so the winner has lowest priority next time.
module rr_arbiter
    import hdmi_island_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [2:0]         grant_idx_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o = '0;
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                win_idx        = cand;
                grant_o[cand]  = 1'b1;
            end
        end
    end

    assign grant_idx_o = 3'(win_idx);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/hdmi_data_island_scheduler.sv
// Schedules one HDMI data island into the horizontal blanking of every line and
// shares its packet slots among NUM_REQ sources by round-robin.
//   pixelClock, resetN : pixel clock, asynchronous active-low reset
//   hBlankStart        : 1-clock pulse on the first blanking clock of a line
//   dataEnable         : active video; high while an island is in progress is a timing fault
//   req / grant        : request/grant pair per source (see below)
//   packetActive       : high for the 32 clocks of a packet slot
//   packetCycle        : 0..31 position inside the current slot
//   packetSource       : index of the source owning the current slot
//   islandPreamble     : high for the 8 preamble clocks
//   islandGuard        : high for the leading and trailing 2-clock guard bands
//   overrunError       : sticky timing-fault flag, cleared only by reset
//   debugState         : current FSM state (ST_* encoding)
//
// Request/grant: req[i] is a level held until granted. Requests are sampled
// only on the last clock of the leading guard or of a packet slot. grant[i]
// pulses for one clock together with packetCycle==0 of the slot it owns; the
// source drops req for that slot and may raise it again from the next clock.
module hdmi_data_island_scheduler
    import hdmi_island_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int H_BLANK       = 370,
    parameter int START_DELAY   = 4,
    parameter int VIDEO_RESERVE = 12,
    parameter int MAX_PACKETS   = 18
) (
    input  logic               pixelClock,
    input  logic               resetN,
    input  logic               hBlankStart,
    input  logic               dataEnable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               packetActive,
    output logic [4:0]         packetCycle,
    output logic [2:0]         packetSource,
    output logic               islandPreamble,
    output logic               islandGuard,
    output logic               overrunError,
    output logic [2:0]         debugState
);

    localparam int         MAXP   = slot_budget(H_BLANK, START_DELAY, VIDEO_RESERVE, MAX_PACKETS);
    localparam logic [4:0] MAXP_C = 5'(MAXP);
    // The pulse clock itself counts as the first delay clock.
    localparam int         DELAY_LEN = (START_DELAY > 1) ? START_DELAY - 1 : 1;
    localparam int         PH_W      = (DELAY_LEN > 32) ? $clog2(DELAY_LEN) : 5;

    logic [2:0]         state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [4:0]         count_q, count_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [2:0]         src_q, src_d;
    logic               err_q, err_d;

    logic               phase_last;
    logic               boundary;
    logic               can_pack;
    logic               advance;
    logic [NUM_REQ-1:0] arb_grant;
    logic [2:0]         arb_idx;

    always_comb begin
        phase_last = 1'b0;
        case (state_q)
            ST_DELAY:                      phase_last = (phase_q == PH_W'(DELAY_LEN - 1));
            ST_PREAMBLE:                   phase_last = (phase_q == PH_W'(PREAMBLE_LEN - 1));
            ST_LEAD_GUARD, ST_TRAIL_GUARD: phase_last = (phase_q == PH_W'(GUARD_LEN - 1));
            ST_PACKET:                     phase_last = (phase_q == PH_W'(PACKET_LEN - 1));
            default:                       phase_last = 1'b0;
        endcase
    end

    assign boundary = phase_last && ((state_q == ST_LEAD_GUARD) || (state_q == ST_PACKET));
    assign can_pack = (|req) && (count_q < MAXP_C);
    // A fault on a boundary clock suppresses the grant and leaves the pointer alone.
    assign advance  = boundary && can_pack && !dataEnable;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i       (pixelClock),
        .rst_ni      (resetN),
        .req_i       (req),
        .advance_i   (advance),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 1'b1;
        count_d = count_q;
        grant_d = '0;
        src_d   = src_q;
        err_d   = err_q;
        if ((state_q != ST_IDLE) && dataEnable) begin
            state_d = ST_IDLE;
            phase_d = '0;
            count_d = '0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    phase_d = '0;
                    if (hBlankStart && (|req) && (MAXP > 0)) begin
                        state_d = (START_DELAY > 1) ? ST_DELAY : ST_PREAMBLE;
                        count_d = '0;
                    end
                end
                ST_DELAY: begin
                    if (phase_last) begin
                        state_d = ST_PREAMBLE;
                        phase_d = '0;
                    end
                end
                ST_PREAMBLE: begin
                    if (phase_last) begin
                        state_d = ST_LEAD_GUARD;
                        phase_d = '0;
                    end
                end
                ST_LEAD_GUARD, ST_PACKET: begin
                    if (phase_last) begin
                        phase_d = '0;
                        if (can_pack) begin
                            state_d = ST_PACKET;
                            grant_d = arb_grant;
                            src_d   = arb_idx;
                            count_d = count_q + 1'b1;
                        end else begin
                            state_d = ST_TRAIL_GUARD;
                        end
                    end
                end
                ST_TRAIL_GUARD: begin
                    if (phase_last) begin
                        state_d = ST_IDLE;
                        phase_d = '0;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            count_q <= '0;
            grant_q <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end

    // Framing is decoded straight from registered state so that a fault or an
    // asynchronous reset clears it without any extra pipeline stage.
    assign islandPreamble = (state_q == ST_PREAMBLE);
    assign islandGuard    = (state_q == ST_LEAD_GUARD) || (state_q == ST_TRAIL_GUARD);
    assign packetActive   = (state_q == ST_PACKET);
    assign packetCycle    = packetActive ? phase_q[4:0] : 5'd0;
    assign packetSource   = packetActive ? src_q : 3'd0;
    assign grant          = grant_q;
    assign overrunError   = err_q;
    assign debugState     = state_q;

endmodule

// File: tb/tb_hdmi_data_island_scheduler.sv
// Self-checking bench for hdmi_data_island_scheduler. A reference model turns
// each line's pending packet counts into an expected per-clock output timeline
// (pushed into exp_q); a monitor compares every clock against it.
module tb_hdmi_data_island_scheduler;
    import hdmi_island_pkg::*;

    localparam int NUM_REQ       = 3;
    localparam int H_BLANK       = 370;
    localparam int START_DELAY   = 4;
    localparam int VIDEO_RESERVE = 12;
    localparam int MAX_PACKETS   = 18;
    localparam int FIT           = (H_BLANK - START_DELAY - 8 - 2 - 2 - VIDEO_RESERVE) / 32;
    localparam int MAXP_TB       = (FIT < MAX_PACKETS) ? FIT : MAX_PACKETS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               resetN;
    logic               hBlankStart;
    logic               dataEnable;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               packetActive;
    logic [4:0]         packetCycle;
    logic [2:0]         packetSource;
    logic               islandPreamble;
    logic               islandGuard;
    logic               overrunError;
    logic [2:0]         debugState;

    hdmi_data_island_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .H_BLANK       (H_BLANK),
        .START_DELAY   (START_DELAY),
        .VIDEO_RESERVE (VIDEO_RESERVE),
        .MAX_PACKETS   (MAX_PACKETS)
    ) dut (
        .pixelClock     (clk),
        .resetN         (resetN),
        .hBlankStart    (hBlankStart),
        .dataEnable     (dataEnable),
        .req            (req),
        .grant          (grant),
        .packetActive   (packetActive),
        .packetCycle    (packetCycle),
        .packetSource   (packetSource),
        .islandPreamble (islandPreamble),
        .islandGuard    (islandGuard),
        .overrunError   (overrunError),
        .debugState     (debugState)
    );

    logic [14:0] obs_word;
    assign obs_word = {islandPreamble, islandGuard, packetActive, packetCycle,
                       packetSource, grant, overrunError};

    // ---------------- scoreboard state ----------------
    logic [13:0] exp_q[$];
    logic        exp_err;
    int          mptr;
    int          pending[NUM_REQ];
    int          n_checks;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [13:0] mk(input logic pre, input logic g, input logic a,
                                       input logic [4:0] c, input logic [2:0] s,
                                       input logic [2:0] gr);
        return {pre, g, a, c, s, gr};
    endfunction

    // Expected timeline of one island, starting with the pulse clock.
    task automatic model_island(input int p0, input int p1, input int p2);
        int p[NUM_REQ];
        int w;
        int n;
        p[0] = p0; p[1] = p1; p[2] = p2;
        repeat (START_DELAY)  exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 3'd0));
        repeat (PREAMBLE_LEN) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 3'd0));
        repeat (GUARD_LEN)    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 3'd0));
        n = 0;
        while (n < MAXP_TB && (p[0] + p[1] + p[2]) > 0) begin
            w = 0;
            for (int k = NUM_REQ - 1; k >= 0; k--)
                if (p[(mptr + k) % NUM_REQ] > 0) w = (mptr + k) % NUM_REQ;
            p[w]--;
            mptr = (w + 1) % NUM_REQ;
            for (int c = 0; c < PACKET_LEN; c++)
                exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 5'(c), 3'(w),
                                   (c == 0) ? 3'(1 << w) : 3'd0));
            n++;
        end
        repeat (GUARD_LEN) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 3'd0));
    endtask

    // Per-clock comparison on the falling edge.
    initial begin
        logic [14:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) e = {exp_q.pop_front(), exp_err};
            else                  e = {14'd0, exp_err};
            check_eq("per_cycle", 32'(obs_word), 32'(e));
        end
    end

    // ---------------- driver tasks ----------------
    // Advance one clock; sources drop a request as soon as they see their grant.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i] && pending[i] > 0) pending[i]--;
        for (int i = 0; i < NUM_REQ; i++) req[i] = (pending[i] > 0);
        hBlankStart = 1'b0;
        dataEnable  = 1'b0;
    endtask

    task automatic flush_model();
        exp_q.delete();
        exp_err = 1'b0;
        mptr    = 0;
        for (int i = 0; i < NUM_REQ; i++) pending[i] = 0;
        req = '0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        flush_model();
        repeat (3) tick();
        resetN = 1'b1;
        tick();
    endtask

    // Add packets to the sources and pulse hBlankStart this clock. With
    // drop_early the caller withdraws them before the first slot boundary.
    task automatic start_line(input int p0, input int p1, input int p2, input bit drop_early);
        pending[0] += p0; pending[1] += p1; pending[2] += p2;
        for (int i = 0; i < NUM_REQ; i++) req[i] = (pending[i] > 0);
        hBlankStart = 1'b1;
        if (|req) begin
            if (drop_early) model_island(0, 0, 0);
            else            model_island(pending[0], pending[1], pending[2]);
        end
        tick();
    endtask

    task automatic wait_idle(input bit spurious);
        int budget;
        budget = 2000;
        while (exp_q.size() > 0 && budget > 0) begin
            if (spurious && $urandom_range(0, 15) == 0) hBlankStart = 1'b1;
            tick();
            budget--;
        end
        if (budget == 0) check_eq("wait_idle_budget", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        hBlankStart = 1'b0;
        dataEnable  = 1'b0;
        resetN      = 1'b0;
        flush_model();

        // Reset state
        do_reset();
        check_eq("reset_outputs", 32'(obs_word), 32'd0);
        check_eq("reset_state", 32'(debugState), 32'(ST_IDLE));

        // Pulses with no requests never open an island
        repeat (5) begin
            start_line(0, 0, 0, 1'b0);
            repeat (20) tick();
        end

        // Single packet from source 0: exact timeline, IDLE at clock 48
        start_line(1, 0, 0, 1'b0);
        repeat (47) tick();
        check_eq("idle_at_48", 32'(debugState), 32'(ST_IDLE));
        wait_idle(1'b0);

        // All sources busy: ten slots in 0,1,2,... order, then trailing guard
        do_reset();
        start_line(5, 5, 5, 1'b0);
        wait_idle(1'b0);
        check_eq("leftover_after_cap", 32'(pending[0] + pending[1] + pending[2]),
                 32'(15 - MAXP_TB));

        // Sources 1 and 2 only, pointer at 0: grants 1,2,1
        do_reset();
        start_line(0, 2, 1, 1'b0);
        wait_idle(1'b0);

        // Randomized lines with ignored mid-island pulses
        for (int line = 0; line < 25; line++) begin
            repeat ($urandom_range(1, 20)) tick();
            start_line($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            wait_idle(1'b1);
        end

        // Request withdrawn before the first boundary: empty island
        do_reset();
        start_line(1, 0, 0, 1'b1);
        repeat (4) tick();
        pending[0] = 0;
        wait_idle(1'b0);

        // Timing fault at clock 20 (mid packet)
        start_line(1, 0, 0, 1'b0);
        repeat (19) tick();
        dataEnable = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        tick();
        exp_err = 1'b1;
        repeat (10) tick();
        check_eq("overrun_sticky", 32'(overrunError), 32'd1);
        start_line(0, 1, 0, 1'b0);
        wait_idle(1'b0);
        check_eq("overrun_still_set", 32'(overrunError), 32'd1);

        // Asynchronous reset at clock 30, then a clean island
        start_line(1, 0, 0, 1'b0);
        repeat (29) tick();
        resetN = 1'b0;
        #1;
        check_eq("async_reset_outputs", 32'(obs_word), 32'd0);
        flush_model();
        repeat (3) tick();
        resetN = 1'b1;
        tick();
        start_line(0, 0, 1, 1'b0);
        wait_idle(1'b0);
        check_eq("error_cleared", 32'(overrunError), 32'd0);
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
